// File: rtl/tank_level_conditioner_pkg.sv
// rtl/tank_level_conditioner_pkg.sv - level codes and thermometer check shared by the level conditioner
package level_pkg;

    localparam logic [2:0] LVL_EMPTY = 3'b000;
    localparam logic [2:0] LVL_LOW   = 3'b001;
    localparam logic [2:0] LVL_MID   = 3'b011;
    localparam logic [2:0] LVL_FULL  = 3'b111;

    // A wet sensor implies every sensor below it is wet too.
    function automatic logic is_thermometer(input logic [2:0] code);
        return (code == LVL_EMPTY) || (code == LVL_LOW) ||
               (code == LVL_MID)   || (code == LVL_FULL);
    endfunction

endpackage

// File: rtl/tank_level_conditioner_if.sv
// rtl/tank_level_conditioner_if.sv - raw switch inputs and conditioned level outputs
interface tank_level_conditioner_if;

    logic [2:0] raw_lvl;
    logic       Nv0;
    logic       Nv1;
    logic       Nv2;
    logic       lvl_valid;
    logic       lvl_fault;
    logic       lvl_chg;

    // master: sensor side / consumer of the conditioned levels
    modport master (
        output raw_lvl,
        input  Nv0, Nv1, Nv2, lvl_valid, lvl_fault, lvl_chg
    );

    // slave: the conditioner itself
    modport slave (
        input  raw_lvl,
        output Nv0, Nv1, Nv2, lvl_valid, lvl_fault, lvl_chg
    );

endinterface

// File: rtl/tank_level_conditioner_debounce_bit.sv
// rtl/tank_level_conditioner_debounce_bit.sv - 2-flop synchronizer plus debounce counter for one switch
module lvl_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Differed for a full window: accept the new level.
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tank_level_conditioner.sv
// rtl/tank_level_conditioner.sv - debounced, validated Nv2/Nv1/Nv0 level outputs with fail-safe full
module tank_level_conditioner
    import level_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    tank_level_conditioner_if.slave   lvl
);

    localparam int            WW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WW-1:0] WARM_MAX = WW'(DEBOUNCE_CYCLES);
    localparam int            FW       = $clog2(FAULT_CYCLES);
    localparam logic [FW-1:0] FCNT_MAX = FW'(FAULT_CYCLES - 1);

    logic [2:0]    code;
    logic [2:0]    nv;
    logic [2:0]    nv_next;
    logic          valid_r;
    logic          valid_next;
    logic          fault_r;
    logic          fault_next;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_next;
    logic          chg_r;
    logic [WW-1:0] warm_cnt;
    logic          warm_done;

    for (genvar i = 0; i < 3; i++) begin : g_deb
        lvl_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (lvl.raw_lvl[i]),
            .deb  (code[i])
        );
    end

    // The reset value of the debounced bits is not a real reading; wait for the
    // synchronizer to fill and one full debounce window before trusting the code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt  <= '0;
            warm_done <= 1'b0;
        end else if (!warm_done) begin
            if (warm_cnt == WARM_MAX) begin
                warm_done <= 1'b1;
            end else begin
                warm_cnt <= warm_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nv_next    = nv;
        valid_next = valid_r;
        fault_next = fault_r;
        fcnt_next  = fcnt;
        if (warm_done) begin
            if (is_thermometer(code)) begin
                nv_next    = code;
                valid_next = 1'b1;
                fault_next = 1'b0;
                fcnt_next  = '0;
            end else if (!fault_r) begin
                if (fcnt == FCNT_MAX) begin
                    fault_next = 1'b1;
                    nv_next    = LVL_FULL;
                end else begin
                    fcnt_next = fcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nv      <= LVL_FULL;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            fcnt    <= '0;
            chg_r   <= 1'b0;
        end else begin
            nv      <= nv_next;
            valid_r <= valid_next;
            fault_r <= fault_next;
            fcnt    <= fcnt_next;
            chg_r   <= (nv_next != nv);
        end
    end

    assign lvl.Nv0       = nv[0];
    assign lvl.Nv1       = nv[1];
    assign lvl.Nv2       = nv[2];
    assign lvl.lvl_valid = valid_r;
    assign lvl.lvl_fault = fault_r;
    assign lvl.lvl_chg   = chg_r;

endmodule

// File: tb/tb_tank_level_conditioner.sv
// tb/tb_tank_level_conditioner.sv - directed vector bench for tank_level_conditioner
module tb_tank_level_conditioner;

    typedef struct {
        logic [2:0] raw;
        int         ticks;
        logic [2:0] nv;
        logic       valid;
        logic       fault;
        logic       chg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vt [17];

    tank_level_conditioner_if t ();

    tank_level_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .FAULT_CYCLES   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lvl  (t.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {t.Nv2, t.Nv1, t.Nv0, t.lvl_valid, t.lvl_fault, t.lvl_chg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got nv/valid/fault/chg=%b want %b", name, got, exp);
        end
    endtask

    task automatic apply(input int i);
        t.raw_lvl = vt[i].raw;
        for (int k = 0; k < vt[i].ticks; k++) tick();
        check($sformatf("vec%0d", i), obs(),
              {vt[i].nv, vt[i].valid, vt[i].fault, vt[i].chg});
    endtask

    // Releases reset with raw=000 held and checks the 6-edge convergence.
    task automatic reset_converge(input string name);
        t.raw_lvl = 3'b000;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check({name, "_in_reset"}, obs(), {3'b111, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check({name, "_edge5"}, obs(), {3'b111, 1'b0, 1'b0, 1'b0});
        tick();
        check({name, "_edge6"}, obs(), {3'b000, 1'b1, 1'b0, 1'b1});
        tick();
        check({name, "_edge7"}, obs(), {3'b000, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        logic       chg_seen;
        logic       fault_seen;
        logic       bad_nv;
        logic [2:0] nvv;

        // raw, ticks, nv, valid, fault, chg
        vt[0]  = '{3'b001, 6,  3'b000, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{3'b001, 1,  3'b001, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{3'b001, 1,  3'b001, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{3'b011, 6,  3'b001, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{3'b011, 1,  3'b011, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{3'b011, 1,  3'b011, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{3'b010, 13, 3'b011, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{3'b010, 1,  3'b111, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{3'b010, 6,  3'b111, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{3'b011, 6,  3'b111, 1'b1, 1'b1, 1'b0};
        vt[10] = '{3'b011, 1,  3'b011, 1'b1, 1'b0, 1'b1};
        vt[11] = '{3'b011, 1,  3'b011, 1'b1, 1'b0, 1'b0};
        vt[12] = '{3'b000, 7,  3'b000, 1'b1, 1'b0, 1'b1};
        vt[13] = '{3'b100, 1,  3'b000, 1'b1, 1'b0, 1'b0};
        vt[14] = '{3'b110, 1,  3'b000, 1'b1, 1'b0, 1'b0};
        vt[15] = '{3'b111, 6,  3'b000, 1'b1, 1'b0, 1'b0};
        vt[16] = '{3'b111, 1,  3'b111, 1'b1, 1'b0, 1'b1};

        reset_converge("rst1");

        for (int i = 0; i <= 2; i++) apply(i);

        // Short glitch on bit1 must never reach the outputs.
        chg_seen  = 1'b0;
        t.raw_lvl = 3'b011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chg_seen |= t.lvl_chg;
        end
        t.raw_lvl = 3'b001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chg_seen |= t.lvl_chg;
        end
        check("glitch_nv", obs(), {3'b001, 1'b1, 1'b0, 1'b0});
        check("glitch_chg", {5'b0, chg_seen}, 6'b0);

        for (int i = 3; i <= 12; i++) apply(i);

        // Staggered 000->111 step: only 000 or 111 may ever appear, no fault.
        fault_seen = 1'b0;
        bad_nv     = 1'b0;
        for (int i = 13; i <= 16; i++) begin
            t.raw_lvl = vt[i].raw;
            for (int k = 0; k < vt[i].ticks; k++) begin
                tick();
                fault_seen |= t.lvl_fault;
                nvv = {t.Nv2, t.Nv1, t.Nv0};
                if (nvv != 3'b000 && nvv != 3'b111) bad_nv = 1'b1;
            end
            check($sformatf("vec%0d", i), obs(),
                  {vt[i].nv, vt[i].valid, vt[i].fault, vt[i].chg});
        end
        check("stagger_no_fault", {5'b0, fault_seen}, 6'b0);
        check("stagger_direct", {5'b0, bad_nv}, 6'b0);
        tick();
        check("stagger_settled", obs(), {3'b111, 1'b1, 1'b0, 1'b0});

        // Async reset with a fault pending.
        t.raw_lvl = 3'b010;
        for (int k = 0; k < 8; k++) tick();
        check("pending_fault", obs(), {3'b111, 1'b1, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", obs(), {3'b111, 1'b0, 1'b0, 1'b0});
        tick();
        reset_converge("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
